// File: rtl/usb_utmi_tx_engine.sv
// UTMI transmit engine: byte FIFO feeding utmi_data_out_o/utmi_txvalid_o on the txready handshake,
// with a forced inter-packet gap and a txready timeout. Single clock domain (ext_clk).
module usb_utmi_tx_engine #(
  parameter int ADDR_WIDTH     = 3,
  parameter int IPG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  ext_clk,
  input  logic                  ext_rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  utmi_txready_i,
  output logic [7:0]            utmi_data_out_o,
  output logic                  utmi_txvalid_o,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  busy,
  output logic                  done,
  output logic [10:0]           tx_count,
  output logic                  err_overflow,
  output logic                  err_timeout,
  output logic                  err_abort
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int IPG_EFF = (IPG_CYCLES < 1) ? 1 : IPG_CYCLES;
  localparam int TO_EFF  = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int GAP_W   = $clog2(IPG_EFF + 1);
  localparam int TO_W    = $clog2(TO_EFF + 1);

  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(IPG_EFF - 1);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TO_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [7:0]          r_data;
  logic [10:0]         r_tx_count;
  logic [TO_W-1:0]     r_to_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_done;
  logic                r_err_overflow;
  logic                r_err_timeout;
  logic                r_err_abort;

  logic [ADDR_WIDTH:0] w_level;
  logic [ADDR_WIDTH:0] w_wr_ptr_next;
  logic                w_empty;
  logic                w_full;
  logic                w_hs;
  logic                w_wr_accept;
  logic                w_pop;
  logic                w_flush;
  logic                w_start_pkt;
  logic                w_done;
  logic                w_timeout;
  logic                w_abort_err;

  assign w_level       = r_wr_ptr - r_rd_ptr;
  assign w_empty       = (w_level == '0);
  assign w_full        = (w_level == DEPTH_L);
  assign w_hs          = (r_state == S_SEND) && utmi_txready_i;
  // A full FIFO still takes a write when the same edge pops a byte out.
  assign w_wr_accept   = wr_en && (!w_full || w_pop);
  assign w_wr_ptr_next = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_accept};

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_start_pkt  = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_abort_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (abort) begin
          w_flush = 1'b1;
        end else if (start && !w_empty) begin
          w_pop        = 1'b1;
          w_start_pkt  = 1'b1;
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_flush      = 1'b1;
          w_abort_err  = 1'b1;
          w_next_state = S_GAP;
        end else if (w_hs) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_done       = 1'b1;
            w_next_state = S_GAP;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_flush      = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        w_flush = abort;
        if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ext_clk or posedge ext_rst) begin
    if (ext_rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_data         <= 8'h00;
      r_tx_count     <= '0;
      r_to_cnt       <= '0;
      r_gap_cnt      <= '0;
      r_done         <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_abort    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_wr_ptr <= w_wr_ptr_next;
      // A flush also discards a byte written on the same edge, leaving the FIFO empty.
      if (w_flush)    r_rd_ptr <= w_wr_ptr_next;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_pop) r_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

      if (w_start_pkt)                     r_tx_count <= '0;
      else if (w_hs && r_tx_count != '1)   r_tx_count <= r_tx_count + 1'b1;

      if (w_start_pkt || w_hs)             r_to_cnt <= '0;
      else if (r_state == S_SEND)          r_to_cnt <= r_to_cnt + TO_W'(1);

      if (r_state == S_GAP && w_next_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                                           r_gap_cnt <= '0;

      r_done <= w_done;

      if (w_start_pkt) begin
        r_err_overflow <= 1'b0;
        r_err_timeout  <= 1'b0;
        r_err_abort    <= 1'b0;
      end
      if (wr_en && !w_wr_accept) r_err_overflow <= 1'b1;
      if (w_timeout)             r_err_timeout  <= 1'b1;
      if (w_abort_err)           r_err_abort    <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge ext_clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign utmi_data_out_o = r_data;
  assign utmi_txvalid_o  = (r_state == S_SEND);
  assign fifo_full       = w_full;
  assign fifo_level      = w_level;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign tx_count        = r_tx_count;
  assign err_overflow    = r_err_overflow;
  assign err_timeout     = r_err_timeout;
  assign err_abort       = r_err_abort;

endmodule
